// File: rtl/ifu_pkg.sv
// ifu_pkg: AHB-Lite constants and IFU fetch-state encoding shared by the prefetch unit.
package ifu_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  typedef enum logic [1:0] {IDLE, BUSY, DROP} ifu_st_e;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: shift-register FIFO whose head entry is a plain register, with flush.
module ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][W-1:0] mem, nxt;
  logic          do_pop;
  logic [AW-1:0] wr_idx;
  assign valid  = count != '0;
  assign do_pop = pop & valid;
  assign wr_idx = AW'(count - CW'(do_pop));
  assign dout   = mem[0];
  always_comb begin
    nxt = mem;
    if (do_pop) for (int i = 0; i < DEPTH - 1; i++) nxt[i] = mem[i + 1];
    if (push) nxt[wr_idx] = din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem   <= '0;
      count <= '0;
    end else begin
      mem   <= nxt;
      count <= flush ? '0 : count + CW'(push) - CW'(do_pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: AHB-Lite instruction prefetcher feeding DECODE from a small queue.
// Define IFU_ERR_EN to tag HRESP=ERROR beats in the queue and halt issue until redirect.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic              run_en,
  input  logic              load_pc_en,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc_to_DECODE,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef IFU_ERR_EN
  localparam int QW = ADDR_W + DATA_W + 1;
`else
  localparam int QW = ADDR_W + DATA_W;
`endif
  ifu_st_e           st, st_nxt;
  logic [ADDR_W-1:0] fetch_pc, inflight_pc, haddr_q;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [QW-1:0]     q_din, q_dout;
  logic              issue, accept, push, err_hold, unused_lo;
  // A non-dropped beat in flight already owns a queue slot.
  assign occ    = {1'b0, count} + (CW + 1)'(st == BUSY);
  assign issue  = ~reset & run_en & ~load_pc_en & ~err_hold & (occ < (CW + 1)'(DEPTH));
  assign accept = issue & HREADY;
  assign push   = (st == BUSY) & HREADY & ~load_pc_en;
  assign HWRITE = 1'b0;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = 3'b000;
`ifdef IFU_ERR_EN
  assign q_din     = {HRESP == HRESP_ERROR, inflight_pc, HRDATA};
  assign fetch_err = q_dout[QW-1];
  assign unused_lo = ^load_pc[1:0];
  always_ff @(posedge clk) begin
    if (reset || load_pc_en) err_hold <= 1'b0;
    else if (push && HRESP == HRESP_ERROR) err_hold <= 1'b1;
  end
`else
  assign q_din     = {inflight_pc, HRDATA};
  assign fetch_err = 1'b0;
  assign err_hold  = 1'b0;
  assign unused_lo = ^{load_pc[1:0], HRESP};
`endif
  assign ir           = q_dout[DATA_W-1:0];
  assign pc_to_DECODE = q_dout[ADDR_W+DATA_W-1:DATA_W];
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else st <= st_nxt;
  end
  always_comb begin
    st_nxt = (st == IDLE) ? (accept ? BUSY : IDLE)
           : !HREADY      ? ((st == BUSY && load_pc_en) ? DROP : st)
           : accept       ? BUSY : IDLE;
  end
  always_comb begin
    HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    HADDR  = issue ? fetch_pc : haddr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      haddr_q     <= RESET_PC;
    end else begin
      if (load_pc_en) fetch_pc <= {load_pc[ADDR_W-1:2], 2'b00};
      else if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (accept) begin
        inflight_pc <= fetch_pc;
        haddr_q     <= fetch_pc;
      end
    end
  end
  ifu_fifo #(.W(QW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (load_pc_en),
    .push  (push),
    .pop   (ir_ready),
    .din   (q_din),
    .dout  (q_dout),
    .valid (ir_valid),
    .count (count)
  );
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch with a zero-wait AHB slave model.
module tb_ifu_prefetch;
`ifdef IFU_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] HADDR, HRDATA, load_pc, ir, pc_to_DECODE;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic        HWRITE, HREADY, run_en, load_pc_en, ir_valid, ir_ready, fetch_err;
  logic [31:0] dp_addr = '0;
  int          n_chk = 0, n_fail = 0;

  ifu_prefetch dut (
    .clk(clk), .reset(reset), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .run_en(run_en), .load_pc_en(load_pc_en), .load_pc(load_pc), .ir(ir),
    .pc_to_DECODE(pc_to_DECODE), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (HTRANS == 2'b10 && HREADY) dp_addr <= HADDR;
  assign HRDATA = dp_addr ^ 32'hDEAD_0000;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; run_en = 1; load_pc_en = 0; load_pc = '0; ir_ready = 1; HREADY = 1; HRESP = 2'b00;
    cyc();
    cyc();
    reset = 0;
    #1;
  endtask

  initial begin
    int found;
    reset = 1; run_en = 1; load_pc_en = 0; load_pc = '0; ir_ready = 1; HREADY = 1; HRESP = 2'b00;
    cyc();
    cyc();
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_pc", pc_to_DECODE, 32'h0);
    check("rst_err", 32'(fetch_err), 32'h0);
    check("rst_const", {HWRITE, HSIZE, HBURST}, 32'b0_010_000);

    // streaming at one word per cycle
    reset = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("t1_htrans", 32'(HTRANS), 32'h2);
      check("t1_haddr", HADDR, 32'(4 * k));
      check("t1_valid", 32'(ir_valid), 32'(k >= 2));
      if (k >= 2) begin
        check("t1_pc", pc_to_DECODE, 32'(4 * (k - 2)));
        check("t1_ir", ir, data_of(32'(4 * (k - 2))));
      end
      cyc();
    end

    // queue fills with DECODE stalled
    do_reset();
    ir_ready = 0;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("t2_htrans", 32'(HTRANS), k < 4 ? 32'h2 : 32'h0);
      check("t2_haddr", HADDR, k < 4 ? 32'(4 * k) : 32'hC);
      cyc();
    end
    check("t2_head_pc", pc_to_DECODE, 32'h0);
    check("t2_head_valid", 32'(ir_valid), 32'h1);
    ir_ready = 1;
    #1;
    found = 0;
    for (int j = 0; j < 6 && found == 0; j++) begin
      if (HTRANS == 2'b10) begin
        found = 1;
        check("t2_resume_addr", HADDR, 32'h10);
      end else cyc();
    end
    check("t2_resume_seen", 32'(found), 32'h1);

    // data-phase stall on 0x8
    do_reset();
    for (int k = 0; k < 10; k++) begin
      HREADY = !(k >= 3 && k <= 5);
      #1;
      if (k >= 3 && k <= 5) begin
        check("t3_hold_addr", HADDR, 32'hC);
        check("t3_hold_trans", 32'(HTRANS), 32'h2);
      end
      if (k >= 4 && k <= 6) check("t3_empty", 32'(ir_valid), 32'h0);
      if (k == 7) check("t3_pc8", pc_to_DECODE, 32'h8);
      if (k == 7) check("t3_ir8", ir, data_of(32'h8));
      if (k == 8) check("t3_pcC", pc_to_DECODE, 32'hC);
      if (k == 9) check("t3_pc10", pc_to_DECODE, 32'h10);
      cyc();
    end

    // redirect while 0x14 is in flight and stalled
    do_reset();
    for (int k = 0; k < 6; k++) cyc();
    HREADY = 0; load_pc_en = 1; load_pc = 32'h200;
    #1;
    check("t4_no_issue", 32'(HTRANS), 32'h0);
    cyc();
    HREADY = 1; load_pc_en = 0;
    #1;
    check("t4_flushed", 32'(ir_valid), 32'h0);
    check("t4_htrans", 32'(HTRANS), 32'h2);
    check("t4_haddr", HADDR, 32'h200);
    cyc();
    check("t4_dropped", 32'(ir_valid), 32'h0);
    cyc();
    check("t4_valid", 32'(ir_valid), 32'h1);
    check("t4_pc", pc_to_DECODE, 32'h200);
    check("t4_ir", ir, data_of(32'h200));
    cyc();
    check("t4_pc2", pc_to_DECODE, 32'h204);

    // unaligned redirect target and run_en gating
    load_pc_en = 1; load_pc = 32'h203;
    #1;
    cyc();
    load_pc_en = 0;
    #1;
    check("t5_haddr", HADDR, 32'h200);
    check("t5_htrans", 32'(HTRANS), 32'h2);
    run_en = 0;
    #1;
    check("t5_run_off", 32'(HTRANS), 32'h0);
    cyc();
    run_en = 1;
    #1;

    // error response on 0x20
    do_reset();
    for (int k = 0; k < 14; k++) begin
      HRESP = (k == 9) ? 2'b01 : 2'b00;
      load_pc_en = (k == 12);
      load_pc = 32'h40;
      #1;
      if (k == 10) begin
        check("t6_pc", pc_to_DECODE, 32'h20);
        check("t6_fetch_err", 32'(fetch_err), 32'(ERR));
      end
      if (k == 11) check("t6_halt", 32'(HTRANS), ERR ? 32'h0 : 32'h2);
      if (k == 13) begin
        check("t6_redir_trans", 32'(HTRANS), 32'h2);
        check("t6_redir_addr", HADDR, 32'h40);
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
